// File: rtl/z80bd_pkg.sv
// z80bd_pkg: region types, wait FSM state encoding and default I/O base port
// shared by the Z80BD mapper blocks.
package z80bd_pkg;
  localparam logic [1:0] REG_SLOW = 2'b00;
  localparam logic [1:0] REG_FAST = 2'b01;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [7:0] DEF_BASE_PORT = 8'h10;
endpackage

// File: rtl/z80bd_edge_sync.sv
// z80bd_edge_sync: two-flop synchroniser for an active-low strobe plus a
// one-cycle pulse on its synchronised falling edge.
module z80bd_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], din};
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= 3'b111;
    else s_q <= s_d;
  assign sync = s_q[1];
  assign fall = s_q[2] & ~s_q[1];
endmodule

// File: rtl/z80bd_mmu.sv
// z80bd_mmu: windowed page mapper driving page address, chip selects and slow-memory waits.
// Define MMU_WAIT_EN to build the wait-state FSM; without it WAIT is tied high.
module z80bd_mmu
  import z80bd_pkg::*;
#(
  parameter int         WINDOWS   = 4,
  parameter int         PAGE_W    = 5,
  parameter logic [7:0] BASE_PORT = DEF_BASE_PORT,
  parameter int         SLOW_WAIT = 2
) (
  input  logic              CLK_24MHz,
  input  logic              RES,
  input  logic [15:0]       A,
  input  logic [7:0]        D_IN,
  output logic [7:0]        D_OUT,
  output logic              D_OE,
  input  logic              IORQ,
  input  logic              MREQ,
  input  logic              RD,
  input  logic              WR,
  output logic [PAGE_W-1:0] M_A,
  output logic              ROM_CE,
  output logic              RAM2_CE,
  output logic              RAM0_CE,
  output logic              RAM1_CE,
  output logic              WAIT
);
  localparam int WB = $clog2(WINDOWS);
  logic [WINDOWS-1:0][7:0] page_q, page_d;
  logic [7:0] sel, off;
  logic hit, slow, fast, io_fall, unused_io_sync, unused_a;
  assign sel = page_q[A[15 -: WB]];
  assign slow = sel[7:6] == REG_SLOW;
  assign fast = sel[7:6] == REG_FAST && sel[5:2] == 4'd0;
  assign M_A = sel[PAGE_W-1:0];
  assign ROM_CE = MREQ | ~slow | sel[5];
  assign RAM2_CE = MREQ | ~slow | ~sel[5];
  assign RAM0_CE = MREQ | ~fast | sel[1];
  assign RAM1_CE = MREQ | ~fast | ~sel[1];
  // Offset from the base port; anything past the last window is a miss.
  assign off = A[7:0] - BASE_PORT;
  assign hit = off < 8'(WINDOWS);
  assign D_OE = ~IORQ & ~RD & hit;
  assign D_OUT = hit ? page_q[off[WB-1:0]] : 8'h00;
  assign unused_a = ^A[15-WB:8];
  z80bd_edge_sync u_io (
    .clk(CLK_24MHz), .rst(RES), .din(IORQ | WR), .sync(unused_io_sync), .fall(io_fall)
  );
  always_comb begin
    page_d = page_q;
    if (io_fall && hit) page_d[off[WB-1:0]] = D_IN;
  end
  always_ff @(posedge CLK_24MHz or posedge RES)
    if (RES) page_q <= '0;
    else page_q <= page_d;
`ifdef MMU_WAIT_EN
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic mreq_s, mreq_fall, refresh;
  // Refresh cycles keep both RD and WR high and must never stall the CPU.
  assign refresh = RD & WR;
  z80bd_edge_sync u_mreq (
    .clk(CLK_24MHz), .rst(RES), .din(MREQ), .sync(mreq_s), .fall(mreq_fall)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (mreq_fall) begin
        state_d = (slow && !refresh && SLOW_WAIT != 0) ? ST_WAIT : ST_HOLD;
        cnt_d = 4'(SLOW_WAIT);
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (refresh || cnt_q <= 4'd1) ? ST_HOLD : ST_WAIT;
      end
      default: state_d = mreq_s ? ST_IDLE : state_q;
    endcase
  end
  always_ff @(posedge CLK_24MHz or posedge RES)
    if (RES) begin
      state_q <= ST_IDLE;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  assign WAIT = state_q != ST_WAIT;
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^4'(SLOW_WAIT);
  assign WAIT = 1'b1;
`endif
endmodule
